// File: rtl/thor2024_tail_alloc.sv
// Instruction-queue tail allocator: grants contiguous free queue slots to packed
// fetch lanes, rewinds the tail on a branch miss and holds off allocation while recovering.
module thor2024_tail_alloc #(
    parameter int unsigned QENTRIES    = 16,
    parameter int unsigned DISPATCH_W  = 4,
    parameter int unsigned PERFORMANCE = 1,
    parameter int unsigned RECOVER_CYC = 1,
    localparam int unsigned NW = $clog2(QENTRIES),
    localparam int unsigned CW = $clog2(DISPATCH_W + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     branchmiss,
    input  logic [QENTRIES-1:0]      iq_stomp,
    input  logic [QENTRIES-1:0]      iq_v,
    input  logic [DISPATCH_W-1:0]    fb_v,
    input  logic [DISPATCH_W-1:0]    fb_backbr,
    output logic [DISPATCH_W*NW-1:0] tail,
    output logic [CW-1:0]            grant_cnt,
    output logic [DISPATCH_W-1:0]    grant_v,
    output logic                     q_full,
    output logic                     recovering
);

    localparam int unsigned    NW1       = NW + 1;
    localparam logic [NW1-1:0] QN        = NW1'(QENTRIES);
    localparam logic [3:0]     RCNT_INIT = (RECOVER_CYC > 0) ? 4'(RECOVER_CYC - 1) : 4'd0;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t          state, state_nx;
    logic [3:0]      rcnt, rcnt_nx;
    logic [NW-1:0]   tail0, tail0_nx;
    logic [NW-1:0]   lane_idx;
    logic            ok;
    logic            rw_found;
    logic [NW-1:0]   rw_idx;
    logic [QENTRIES-1:0] stomp_prev;
    logic [QENTRIES-1:0] stomp_edge;

    // Modulo add by a single conditional subtract; b is always < QENTRIES.
    function automatic logic [NW-1:0] wrap_add(input logic [NW-1:0] a, input logic [NW1-1:0] b);
        logic [NW1-1:0] s;
        s = {1'b0, a} + b;
        if (s >= QN) begin
            s = s - QN;
        end
        return s[NW-1:0];
    endfunction

    // Lane slot indices and thermometer grant chain.
    always_comb begin
        tail      = '0;
        grant_v   = '0;
        grant_cnt = '0;
        lane_idx  = '0;
        ok        = rst_n & (state == RUN) & ~branchmiss;
        for (int i = 0; i < DISPATCH_W; i++) begin
            lane_idx = wrap_add(tail0, NW1'(i));
            tail[i*NW +: NW] = lane_idx;
            if (i > 0) begin
                ok = ok & ~fb_backbr[i-1];
            end
            ok         = ok & fb_v[i] & ~iq_v[lane_idx];
            grant_v[i] = ok;
            grant_cnt  = grant_cnt + CW'(ok);
        end
    end

    assign q_full = iq_v[tail0];

    // Oldest stomped entry: a set bit whose circular predecessor is clear; lowest index wins.
    assign stomp_prev = {iq_stomp[QENTRIES-2:0], iq_stomp[QENTRIES-1]};
    assign stomp_edge = iq_stomp & ~stomp_prev;

    always_comb begin
        rw_found = 1'b0;
        rw_idx   = '0;
        for (int j = QENTRIES - 1; j >= 0; j--) begin
            if (stomp_edge[j]) begin
                rw_found = 1'b1;
                rw_idx   = NW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            rcnt       <= 4'd0;
            tail0      <= '0;
            recovering <= 1'b0;
        end else begin
            state      <= state_nx;
            rcnt       <= rcnt_nx;
            tail0      <= tail0_nx;
            recovering <= (state_nx == RECOVER);
        end
    end

    // Next state: a miss always wins and restarts the recovery window.
    always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt;
        tail0_nx = tail0;
        if (branchmiss) begin
            if ((PERFORMANCE != 0) && rw_found) begin
                tail0_nx = rw_idx;
            end
            if (RECOVER_CYC != 0) begin
                state_nx = RECOVER;
                rcnt_nx  = RCNT_INIT;
            end else begin
                state_nx = RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    tail0_nx = wrap_add(tail0, NW1'(grant_cnt));
                end
                RECOVER: begin
                    if (rcnt == 4'd0) begin
                        state_nx = RUN;
                    end else begin
                        rcnt_nx = rcnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thor2024_tail_alloc.sv
// Self-checking bench for thor2024_tail_alloc: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a queue-level model.
module tb_thor2024_tail_alloc;

    localparam int Q  = 16;
    localparam int W  = 4;
    localparam int RC = 2;
    localparam int NW = $clog2(Q);
    localparam int CW = $clog2(W + 1);

    logic            clk;
    logic            rst_n;
    logic            branchmiss;
    logic [Q-1:0]    iq_stomp;
    logic [Q-1:0]    iq_v;
    logic [W-1:0]    fb_v;
    logic [W-1:0]    fb_backbr;
    logic [W*NW-1:0] tail;
    logic [CW-1:0]   grant_cnt;
    logic [W-1:0]    grant_v;
    logic            q_full;
    logic            recovering;

    int total = 0;
    int bad   = 0;

    // Model state: tail pointer and number of blocked cycles still to come.
    int m_tail = 0;
    int m_rec  = 0;

    int              e_cnt;
    logic [W*NW-1:0] e_tail;

    thor2024_tail_alloc #(
        .QENTRIES   (Q),
        .DISPATCH_W (W),
        .PERFORMANCE(1),
        .RECOVER_CYC(RC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .branchmiss(branchmiss),
        .iq_stomp  (iq_stomp),
        .iq_v      (iq_v),
        .fb_v      (fb_v),
        .fb_backbr (fb_backbr),
        .tail      (tail),
        .grant_cnt (grant_cnt),
        .grant_v   (grant_v),
        .q_full    (q_full),
        .recovering(recovering)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Lanes accepted in order until a missing lane, an occupied slot, or just past a backward branch.
    function automatic int mgrant();
        int c = 0;
        for (int i = 0; i < W; i++) begin
            if (!fb_v[i] || iq_v[(m_tail + i) % Q]) break;
            c++;
            if (fb_backbr[i]) break;
        end
        return c;
    endfunction

    function automatic int mrewind(input int cur);
        for (int j = 0; j < Q; j++) begin
            if (iq_stomp[j] && !iq_stomp[(j + Q - 1) % Q]) return j;
        end
        return cur;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tail = 0;
            m_rec  = 0;
        end else if (branchmiss) begin
            m_tail = mrewind(m_tail);
            m_rec  = RC;
        end else if (m_rec > 0) begin
            m_rec = m_rec - 1;
        end else begin
            m_tail = (m_tail + mgrant()) % Q;
        end
    end

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        e_cnt = (rst_n && m_rec == 0 && !branchmiss) ? mgrant() : 0;
        for (int i = 0; i < W; i++) e_tail[i*NW +: NW] = NW'((m_tail + i) % Q);
        chk("grant_cnt", longint'(grant_cnt), longint'(e_cnt));
        chk("grant_v", longint'(grant_v), longint'((1 << e_cnt) - 1));
        chk("q_full", longint'(q_full), longint'(iq_v[m_tail]));
        chk("tail", longint'(tail), longint'(e_tail));
        chk("recovering", longint'(recovering), longint'(m_rec > 0));
    end

    task automatic drive(input logic [W-1:0] v, input logic [W-1:0] bb, input logic [Q-1:0] occ,
                         input logic miss, input logic [Q-1:0] st);
        fb_v       = v;
        fb_backbr  = bb;
        iq_v       = occ;
        branchmiss = miss;
        iq_stomp   = st;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [Q-1:0] st;
        int n, s, l;
        rst_n = 1'b0;
        drive(4'hF, 4'h0, '0, 1'b0, '0);
        @(negedge clk);
        chk("rst_tail", longint'(tail), 64'h3210);
        chk("rst_grant", longint'(grant_cnt), 0);
        chk("rst_rec", longint'(recovering), 0);

        next_cycle(); rst_n = 1'b1;
        @(negedge clk);
        chk("first_grant", longint'(grant_cnt), 4);
        chk("first_gv", longint'(grant_v), 4'hF);

        next_cycle(); drive(4'hF, 4'b0010, '0, 1'b0, '0);
        @(negedge clk);
        chk("tail_after4", longint'(tail[NW-1:0]), 4);
        chk("backbr_gv", longint'(grant_v), 4'b0011);

        next_cycle(); drive(4'hF, 4'h0, '0, 1'b0, '0);
        @(negedge clk);
        chk("tail_after_bb", longint'(tail[NW-1:0]), 6);
        next_cycle();
        next_cycle(); drive(4'hF, 4'h0, 16'h0001, 1'b0, '0);
        @(negedge clk);
        chk("tail14", longint'(tail[NW-1:0]), 14);
        chk("partial_cnt", longint'(grant_cnt), 2);
        chk("partial_gv", longint'(grant_v), 4'b0011);
        chk("partial_notfull", longint'(q_full), 0);

        next_cycle();
        @(negedge clk);
        chk("wrap_tail0", longint'(tail[NW-1:0]), 0);
        chk("full_flag", longint'(q_full), 1);
        chk("full_cnt", longint'(grant_cnt), 0);

        next_cycle(); drive(4'hF, 4'h0, '0, 1'b1, 16'hF00F);
        @(negedge clk);
        chk("miss_cnt", longint'(grant_cnt), 0);
        next_cycle(); drive(4'hF, 4'h0, '0, 1'b0, '0);
        @(negedge clk);
        chk("rewind12", longint'(tail[NW-1:0]), 12);
        chk("rec1", longint'(recovering), 1);
        chk("rec1_cnt", longint'(grant_cnt), 0);
        next_cycle();
        @(negedge clk);
        chk("rec2", longint'(recovering), 1);
        chk("rec2_cnt", longint'(grant_cnt), 0);
        next_cycle();
        @(negedge clk);
        chk("run_again", longint'(recovering), 0);
        chk("run_cnt", longint'(grant_cnt), 4);

        next_cycle(); drive(4'hF, 4'h0, '0, 1'b1, 16'h0000);
        @(negedge clk);
        chk("nostomp_tail", longint'(tail[NW-1:0]), 0);
        next_cycle(); drive(4'hF, 4'h0, '0, 1'b1, 16'h00F0);
        @(negedge clk);
        chk("miss_in_rec", longint'(recovering), 1);
        next_cycle(); drive(4'hF, 4'h0, '0, 1'b0, '0);
        @(negedge clk);
        chk("rewind4", longint'(tail[NW-1:0]), 4);
        chk("restart_rec1", longint'(recovering), 1);
        next_cycle();
        @(negedge clk);
        chk("restart_rec2", longint'(recovering), 1);

        next_cycle(); #2 rst_n = 1'b0;
        #1;
        chk("async_tail", longint'(tail), 64'h3210);
        chk("async_rec", longint'(recovering), 0);
        next_cycle(); rst_n = 1'b1;

        for (int k = 0; k < 3000; k++) begin
            next_cycle();
            n = $urandom_range(W, 0);
            fb_v = W'((1 << n) - 1);
            if ($urandom_range(7, 0) == 0) fb_v = W'($urandom);
            fb_backbr  = W'($urandom & $urandom);
            iq_v       = Q'($urandom & $urandom & $urandom);
            branchmiss = ($urandom_range(11, 0) == 0);
            if ($urandom_range(1, 0) == 0) begin
                st = '0;
                s  = $urandom_range(Q - 1, 0);
                l  = $urandom_range(Q, 0);
                for (int b = 0; b < l; b++) st[(s + b) % Q] = 1'b1;
                iq_stomp = st;
            end else begin
                iq_stomp = Q'($urandom);
            end
        end

        next_cycle();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
